// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave: FSM states, ACK/NACK levels, address width.
package i2c_pkg;

   localparam int   ADDR_W = 7;
   localparam logic ACK    = 1'b0;
   localparam logic NACK   = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      RX,
      RX_ACK,
      TX,
      TX_ACK,
      WAIT_STOP
   } state_t;

   // True when the upper seven bits of an address byte select this slave.
   function automatic logic addr_hit(input logic [7:0] frame_byte,
                                     input logic [ADDR_W-1:0] slv_addr);
      return frame_byte[7:1] == slv_addr;
   endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// User-side data/status bundle of the I2C slave (everything except the bus pins).
interface i2c_slave_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_req;
   logic [5:0] byte_count;
   logic       busy;
   logic       overflow;
   logic       frame_done;

   modport slave (
      output rx_data, rx_valid, tx_req, byte_count, busy, overflow, frame_done,
      input  tx_data
   );

   modport master (
      input  rx_data, rx_valid, tx_req, byte_count, busy, overflow, frame_done,
      output tx_data
   );

endinterface

// File: rtl/i2c_line_sync.sv
// Brings scl/sda into the clk domain and derives bus edge and START/STOP events.
module i2c_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_sync
);

   // [0] first sync flop, [1] synchronised level, [2] history for edge detection
   logic [2:0] scl_sh_reg;
   logic [2:0] sda_sh_reg;

   // Two-flop synchronisers plus history; reset to the idle (released) bus level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scl_sh_reg <= 3'b111;
         sda_sh_reg <= 3'b111;
      end else begin
         scl_sh_reg <= {scl_sh_reg[1:0], scl};
         sda_sh_reg <= {sda_sh_reg[1:0], sda};
      end
   end

   assign scl_rise  =  scl_sh_reg[1] & ~scl_sh_reg[2];
   assign scl_fall  = ~scl_sh_reg[1] &  scl_sh_reg[2];
   assign start_det =  sda_sh_reg[2] & ~sda_sh_reg[1] & scl_sh_reg[1];
   assign stop_det  = ~sda_sh_reg[2] &  sda_sh_reg[1] & scl_sh_reg[1];
   assign sda_sync  =  sda_sh_reg[1];

endmodule

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit address match, byte write with overflow NACK, byte read.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SLV_ADDR  = 7'h3C,
   parameter int                MAX_BYTES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl,
   inout  wire         sda,
   i2c_slave_if.slave  usr
);

   localparam logic [5:0] MAX_BC = 6'(MAX_BYTES);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_line_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_sync  (sda_s)
   );

   state_t     state_reg, state_next;
   logic [3:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic       ack_phase_reg, ack_phase_next;   // ACK slot: first fall seen / master ACK seen
   logic       rw_reg, rw_next;
   logic       sda_oe_reg, sda_oe_next;         // 1 = pull sda low
   logic [7:0] rx_data_reg, rx_data_next;
   logic       rx_valid_reg, rx_valid_next;
   logic       tx_req_reg, tx_req_next;
   logic [5:0] byte_count_reg, byte_count_next;
   logic       busy_reg, busy_next;
   logic       overflow_reg, overflow_next;
   logic       frame_done_reg, frame_done_next;
   logic [7:0] shifted;

   // Open-drain output; reset releases the line without waiting for a clk edge.
   assign sda = (sda_oe_reg && rst_n) ? 1'b0 : 1'bz;

   assign usr.rx_data    = rx_data_reg;
   assign usr.rx_valid   = rx_valid_reg;
   assign usr.tx_req     = tx_req_reg;
   assign usr.byte_count = byte_count_reg;
   assign usr.busy       = busy_reg;
   assign usr.overflow   = overflow_reg;
   assign usr.frame_done = frame_done_reg;

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         ack_phase_reg  <= 1'b0;
         rw_reg         <= 1'b0;
         sda_oe_reg     <= 1'b0;
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         tx_req_reg     <= 1'b0;
         byte_count_reg <= '0;
         busy_reg       <= 1'b0;
         overflow_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         ack_phase_reg  <= ack_phase_next;
         rw_reg         <= rw_next;
         sda_oe_reg     <= sda_oe_next;
         rx_data_reg    <= rx_data_next;
         rx_valid_reg   <= rx_valid_next;
         tx_req_reg     <= tx_req_next;
         byte_count_reg <= byte_count_next;
         busy_reg       <= busy_next;
         overflow_reg   <= overflow_next;
         frame_done_reg <= frame_done_next;
      end
   end

   // Next-state and output logic; STOP beats START, both beat bit sampling.
   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      shift_next      = shift_reg;
      ack_phase_next  = ack_phase_reg;
      rw_next         = rw_reg;
      sda_oe_next     = sda_oe_reg;
      rx_data_next    = rx_data_reg;
      rx_valid_next   = 1'b0;
      tx_req_next     = 1'b0;
      byte_count_next = byte_count_reg;
      busy_next       = busy_reg;
      overflow_next   = overflow_reg;
      frame_done_next = 1'b0;
      shifted         = {shift_reg[6:0], sda_s};

      if (stop_det) begin
         state_next      = IDLE;
         sda_oe_next     = 1'b0;
         busy_next       = 1'b0;
         frame_done_next = busy_reg;
      end else if (start_det) begin
         state_next      = ADDR;
         bit_cnt_next    = '0;
         byte_count_next = '0;
         overflow_next   = 1'b0;
         sda_oe_next     = 1'b0;
         ack_phase_next  = 1'b0;
      end else begin
         case (state_reg)
            ADDR: begin
               if (scl_rise) begin
                  shift_next   = shifted;
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7) begin
                     bit_cnt_next = '0;
                     if (addr_hit(shifted, SLV_ADDR)) begin
                        state_next     = ADDR_ACK;
                        rw_next        = sda_s;
                        busy_next      = 1'b1;
                        ack_phase_next = 1'b0;
                     end else begin
                        state_next = IDLE;
                     end
                  end
               end
            end

            ADDR_ACK, RX_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase_reg) begin
                     // Falling edge after the 8th bit: start driving ACK.
                     ack_phase_next = 1'b1;
                     sda_oe_next    = (ACK == 1'b0);
                  end else begin
                     ack_phase_next = 1'b0;
                     bit_cnt_next   = '0;
                     if (state_reg == ADDR_ACK && rw_reg) begin
                        state_next  = TX;
                        shift_next  = usr.tx_data;
                        tx_req_next = 1'b1;
                        sda_oe_next = ~usr.tx_data[7];
                     end else begin
                        state_next  = RX;
                        sda_oe_next = 1'b0;
                     end
                  end
               end
            end

            RX: begin
               if (scl_rise) begin
                  shift_next   = shifted;
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd7) begin
                     bit_cnt_next = '0;
                     if (byte_count_reg < MAX_BC) begin
                        rx_data_next    = shifted;
                        rx_valid_next   = 1'b1;
                        byte_count_next = byte_count_reg + 6'd1;
                        state_next      = RX_ACK;
                        ack_phase_next  = 1'b0;
                     end else begin
                        overflow_next = 1'b1;
                        sda_oe_next   = 1'b0;
                        state_next    = WAIT_STOP;
                     end
                  end
               end
            end

            TX: begin
               if (scl_rise) begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_reg == 4'd8) begin
                     state_next     = TX_ACK;
                     sda_oe_next    = 1'b0;
                     ack_phase_next = 1'b0;
                     bit_cnt_next   = '0;
                  end else begin
                     shift_next  = {shift_reg[6:0], 1'b0};
                     sda_oe_next = ~shift_reg[6];
                  end
               end
            end

            TX_ACK: begin
               if (scl_rise && !ack_phase_reg) begin
                  if (sda_s == ACK) begin
                     ack_phase_next = 1'b1;
                     if (byte_count_reg < MAX_BC) begin
                        byte_count_next = byte_count_reg + 6'd1;
                     end
                  end else begin
                     state_next = WAIT_STOP;
                  end
               end else if (scl_fall && ack_phase_reg) begin
                  // Master ACKed: fetch and present the next byte.
                  ack_phase_next = 1'b0;
                  bit_cnt_next   = '0;
                  state_next     = TX;
                  shift_next     = usr.tx_data;
                  tx_req_next    = 1'b1;
                  sda_oe_next    = ~usr.tx_data[7];
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave, checked against a frame-level model.
module tb_i2c_slave;
   import i2c_pkg::*;

   localparam int Q = 5;   // clk cycles per quarter of an scl bit

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl = 1'b1;
   logic sda_m_low = 1'b0;
   wire  sda_bus;

   pullup (sda_bus);
   assign sda_bus = sda_m_low ? 1'b0 : 1'bz;

   i2c_slave_if usr ();

   i2c_slave #(.SLV_ADDR(7'h3C), .MAX_BYTES(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .scl   (scl),
      .sda   (sda_bus),
      .usr   (usr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // Monitor state (single writer: the block below)
   logic [7:0] rx_seen[$];
   int tx_cnt = 0;
   int fd_cnt = 0;
   int dut_low_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (usr.rx_valid) rx_seen.push_back(usr.rx_data);
         if (usr.tx_req) tx_cnt++;
         if (usr.frame_done) fd_cnt++;
         if (sda_bus === 1'b0 && !sda_m_low) dut_low_cnt++;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "timeout");
   end

   logic       ack_q[$];
   logic [7:0] wr_data[$];

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic m_start();
      wq(); sda_m_low = 1'b0;
      wq(); scl = 1'b1;
      wq(); sda_m_low = 1'b1;
      wq(); scl = 1'b0;
   endtask

   task automatic m_stop();
      wq(); sda_m_low = 1'b1;
      wq(); scl = 1'b1;
      wq(); sda_m_low = 1'b0;
      wq(); wq();
   endtask

   task automatic m_bit(input logic b, output logic s);
      wq(); sda_m_low = ~b;
      wq(); scl = 1'b1;
      wq(); s = sda_bus;
      wq(); scl = 1'b0;
   endtask

   task automatic m_write(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) m_bit(d[i], s);
      m_bit(1'b1, ack);
   endtask

   task automatic m_read_bits(output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, s);
         d[i] = s;
      end
   endtask

   // START, address byte, then wr_data[0..n-1]; leaves the bus before STOP.
   task automatic do_write(input logic [7:0] abyte, input int n);
      logic a;
      ack_q.delete();
      m_start();
      m_write(abyte, a);
      ack_q.push_back(a);
      for (int k = 0; k < n; k++) begin
         m_write(wr_data[k], a);
         ack_q.push_back(a);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if (usr.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data actual=%h required=00", usr.rx_data); end
      n_checks++; if ({usr.rx_valid, usr.tx_req, usr.busy, usr.overflow, usr.frame_done} !== 5'b0) begin n_fail++; $display("FAIL reset_flags actual=%b required=00000", {usr.rx_valid, usr.tx_req, usr.busy, usr.overflow, usr.frame_done}); end
      n_checks++; if (usr.byte_count !== 6'd0) begin n_fail++; $display("FAIL reset_byte_count actual=%0d required=0", usr.byte_count); end
      n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda actual=%b required=1", sda_bus); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      $display("reset done");
   endtask

   task automatic test_write();
      int rx0 = rx_seen.size();
      int fd0 = fd_cnt;
      wr_data = '{8'hA5, 8'h5A};
      do_write(8'h78, 2);
      foreach (ack_q[i]) begin
         n_checks++; if (ack_q[i] !== ACK) begin n_fail++; $display("FAIL write_ack%0d actual=%b required=0", i, ack_q[i]); end
      end
      n_checks++; if (rx_seen.size() - rx0 != 2) begin n_fail++; $display("FAIL write_rx_pulses actual=%0d required=2", rx_seen.size() - rx0); end
      else begin
         n_checks++; if (rx_seen[rx0] !== 8'hA5 || rx_seen[rx0+1] !== 8'h5A) begin n_fail++; $display("FAIL write_rx_bytes actual=%h,%h required=a5,5a", rx_seen[rx0], rx_seen[rx0+1]); end
      end
      n_checks++; if (usr.byte_count !== 6'd2) begin n_fail++; $display("FAIL write_byte_count actual=%0d required=2", usr.byte_count); end
      n_checks++; if (usr.busy !== 1'b1) begin n_fail++; $display("FAIL write_busy actual=%b required=1", usr.busy); end
      m_stop();
      n_checks++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL write_frame_done actual=%0d required=1", fd_cnt - fd0); end
      n_checks++; if (usr.busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop actual=%b required=0", usr.busy); end
      $display("write frame addr=78 bytes=a5,5a");
   endtask

   task automatic test_addr_miss();
      int rx0 = rx_seen.size();
      int fd0 = fd_cnt;
      int low0 = dut_low_cnt;
      wr_data = '{8'h11};
      do_write(8'h7A, 1);
      n_checks++; if (usr.busy !== 1'b0) begin n_fail++; $display("FAIL miss_busy actual=%b required=0", usr.busy); end
      m_stop();
      n_checks++; if (ack_q[0] !== NACK) begin n_fail++; $display("FAIL miss_addr_ack actual=%b required=1", ack_q[0]); end
      n_checks++; if (dut_low_cnt != low0) begin n_fail++; $display("FAIL miss_sda_driven actual=%0d required=0", dut_low_cnt - low0); end
      n_checks++; if (rx_seen.size() != rx0) begin n_fail++; $display("FAIL miss_rx_valid actual=%0d required=0", rx_seen.size() - rx0); end
      n_checks++; if (fd_cnt != fd0) begin n_fail++; $display("FAIL miss_frame_done actual=%0d required=0", fd_cnt - fd0); end
      $display("write frame addr=7a (miss) bytes=11");
   endtask

   task automatic test_read();
      logic a, s;
      logic [7:0] d0, d1;
      int tx0 = tx_cnt;
      int fd0 = fd_cnt;
      usr.tx_data = 8'h81;
      m_start();
      m_write(8'h79, a);
      n_checks++; if (a !== ACK) begin n_fail++; $display("FAIL read_addr_ack actual=%b required=0", a); end
      m_read_bits(d0);
      usr.tx_data = 8'h3C;
      m_bit(ACK, s);
      m_read_bits(d1);
      m_bit(NACK, s);
      wq();
      n_checks++; if (d0 !== 8'h81) begin n_fail++; $display("FAIL read_byte0 actual=%b required=10000001", d0); end
      n_checks++; if (d1 !== 8'h3C) begin n_fail++; $display("FAIL read_byte1 actual=%b required=00111100", d1); end
      n_checks++; if (tx_cnt - tx0 != 2) begin n_fail++; $display("FAIL read_tx_req actual=%0d required=2", tx_cnt - tx0); end
      n_checks++; if (dut.state_reg !== WAIT_STOP) begin n_fail++; $display("FAIL read_state actual=%0d required=%0d", dut.state_reg, WAIT_STOP); end
      n_checks++; if (usr.byte_count !== 6'd1) begin n_fail++; $display("FAIL read_byte_count actual=%0d required=1", usr.byte_count); end
      m_stop();
      n_checks++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL read_frame_done actual=%0d required=1", fd_cnt - fd0); end
      $display("read frame addr=79 bytes=%h,%h", d0, d1);
   endtask

   task automatic test_overflow();
      int rx0 = rx_seen.size();
      int n_ack = 0;
      wr_data.delete();
      for (int i = 0; i <= 32; i++) wr_data.push_back(8'(i));
      do_write(8'h78, 33);
      for (int i = 1; i <= 32; i++) if (ack_q[i] == ACK) n_ack++;
      n_checks++; if (n_ack != 32) begin n_fail++; $display("FAIL ovf_acks actual=%0d required=32", n_ack); end
      n_checks++; if (ack_q[33] !== NACK) begin n_fail++; $display("FAIL ovf_33rd_ack actual=%b required=1", ack_q[33]); end
      n_checks++; if (usr.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag actual=%b required=1", usr.overflow); end
      n_checks++; if (usr.byte_count !== 6'd32) begin n_fail++; $display("FAIL ovf_byte_count actual=%0d required=32", usr.byte_count); end
      n_checks++; if (usr.rx_data !== 8'h1F) begin n_fail++; $display("FAIL ovf_rx_data actual=%h required=1f", usr.rx_data); end
      n_checks++; if (rx_seen.size() - rx0 != 32) begin n_fail++; $display("FAIL ovf_rx_pulses actual=%0d required=32", rx_seen.size() - rx0); end
      m_stop();
      $display("write frame addr=78 bytes=00..20 (overflow)");
   endtask

   task automatic test_repeated_start();
      logic a, s;
      logic [7:0] tb, d;
      int tx0;
      wr_data = '{8'h01};
      do_write(8'h78, 1);
      n_checks++; if (usr.byte_count !== 6'd1) begin n_fail++; $display("FAIL rstart_pre_count actual=%0d required=1", usr.byte_count); end
      tb = 8'($urandom_range(0, 255));
      usr.tx_data = tb;
      tx0 = tx_cnt;
      m_start();
      m_write(8'h79, a);
      wq();
      n_checks++; if (a !== ACK) begin n_fail++; $display("FAIL rstart_addr_ack actual=%b required=0", a); end
      n_checks++; if (usr.byte_count !== 6'd0) begin n_fail++; $display("FAIL rstart_count_cleared actual=%0d required=0", usr.byte_count); end
      n_checks++; if (dut.state_reg !== TX) begin n_fail++; $display("FAIL rstart_state actual=%0d required=%0d", dut.state_reg, TX); end
      n_checks++; if (tx_cnt - tx0 != 1) begin n_fail++; $display("FAIL rstart_tx_req actual=%0d required=1", tx_cnt - tx0); end
      m_read_bits(d);
      m_bit(NACK, s);
      n_checks++; if (d !== tb) begin n_fail++; $display("FAIL rstart_read actual=%h required=%h", d, tb); end
      m_stop();
      $display("write 78/01 then repeated start read 79 byte=%h", d);
   endtask

   task automatic test_reset_ack();
      logic s, a;
      logic [7:0] abyte = 8'h78;
      int rx0, low0, fd0;
      m_start();
      for (int i = 7; i >= 0; i--) m_bit(abyte[i], s);
      wq(); sda_m_low = 1'b0;
      wq();
      n_checks++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL rstack_ack_driven actual=%b required=0", sda_bus); end
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rstack_sda_release actual=%b required=1", sda_bus); end
      n_checks++; if ({usr.busy, usr.overflow, usr.rx_valid, usr.tx_req, usr.frame_done} !== 5'b0 || usr.byte_count !== 6'd0 || usr.rx_data !== 8'h00) begin
         n_fail++; $display("FAIL rstack_outputs actual=flags %b count %0d rx %h required=flags 00000 count 0 rx 00", {usr.busy, usr.overflow, usr.rx_valid, usr.tx_req, usr.frame_done}, usr.byte_count, usr.rx_data);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rx0 = rx_seen.size(); low0 = dut_low_cnt; fd0 = fd_cnt;
      scl = 1'b1; wq(); wq(); scl = 1'b0;
      m_write(8'h55, a);
      m_stop();
      n_checks++; if (a !== NACK) begin n_fail++; $display("FAIL rstack_no_ack actual=%b required=1", a); end
      n_checks++; if (dut_low_cnt != low0 || rx_seen.size() != rx0 || fd_cnt != fd0) begin
         n_fail++; $display("FAIL rstack_ignored actual=low %0d rx %0d fd %0d required=0 0 0", dut_low_cnt - low0, rx_seen.size() - rx0, fd_cnt - fd0);
      end
      $display("reset during ACK, then byte 55 without START");
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         int kind = $urandom_range(0, 2);
         int rx0 = rx_seen.size();
         int fd0 = fd_cnt;
         int tx0 = tx_cnt;
         if (kind < 2) begin
            // Write frame: model derives ACKs, delivered bytes and count from frame contents
            logic [6:0] a7 = 7'h3C;
            int n = $urandom_range(0, 4);
            logic hit;
            int n_exp;
            if (kind == 1) begin
               do a7 = 7'($urandom_range(0, 127)); while (a7 == 7'h3C);
            end
            hit = (a7 == 7'h3C);
            wr_data.delete();
            for (int k = 0; k < n; k++) wr_data.push_back(8'($urandom_range(0, 255)));
            do_write({a7, 1'b0}, n);
            n_exp = hit ? n : 0;
            for (int k = 0; k <= n; k++) begin
               n_checks++; if (ack_q[k] !== (hit ? ACK : NACK)) begin n_fail++; $display("FAIL rnd%0d_ack%0d actual=%b required=%b", f, k, ack_q[k], hit ? ACK : NACK); end
            end
            n_checks++; if (usr.byte_count !== 6'(n_exp)) begin n_fail++; $display("FAIL rnd%0d_count actual=%0d required=%0d", f, usr.byte_count, n_exp); end
            m_stop();
            n_checks++; if (rx_seen.size() - rx0 != n_exp) begin n_fail++; $display("FAIL rnd%0d_rx_pulses actual=%0d required=%0d", f, rx_seen.size() - rx0, n_exp); end
            else begin
               for (int k = 0; k < n_exp; k++) begin
                  n_checks++; if (rx_seen[rx0+k] !== wr_data[k]) begin n_fail++; $display("FAIL rnd%0d_rx%0d actual=%h required=%h", f, k, rx_seen[rx0+k], wr_data[k]); end
               end
            end
            n_checks++; if (fd_cnt - fd0 != (hit ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_fd actual=%0d required=%0d", f, fd_cnt - fd0, hit ? 1 : 0); end
            $display("random write frame %0d addr=%h hit=%0d bytes=%0d", f, a7, hit, n);
         end else begin
            // Read frame: master ACKs all but the last byte
            logic a, s;
            logic [7:0] d;
            logic [7:0] tq[$];
            int n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) tq.push_back(8'($urandom_range(0, 255)));
            usr.tx_data = tq[0];
            m_start();
            m_write(8'h79, a);
            n_checks++; if (a !== ACK) begin n_fail++; $display("FAIL rnd%0d_raddr actual=%b required=0", f, a); end
            for (int k = 0; k < n; k++) begin
               m_read_bits(d);
               n_checks++; if (d !== tq[k]) begin n_fail++; $display("FAIL rnd%0d_rbyte%0d actual=%h required=%h", f, k, d, tq[k]); end
               if (k + 1 < n) usr.tx_data = tq[k+1];
               m_bit((k + 1 < n) ? ACK : NACK, s);
            end
            n_checks++; if (usr.byte_count !== 6'(n - 1)) begin n_fail++; $display("FAIL rnd%0d_rcount actual=%0d required=%0d", f, usr.byte_count, n - 1); end
            n_checks++; if (tx_cnt - tx0 != n) begin n_fail++; $display("FAIL rnd%0d_tx_req actual=%0d required=%0d", f, tx_cnt - tx0, n); end
            m_stop();
            $display("random read frame %0d bytes=%0d", f, n);
         end
      end
   endtask

   initial begin
      usr.tx_data = 8'h00;
      test_reset();
      test_write();
      test_addr_miss();
      test_read();
      test_overflow();
      test_repeated_start();
      test_reset_ack();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLV_ADDR, default 7'h3C: the 7-bit bus address the block answers to.
REQ-002 SHALL have parameter MAX_BYTES, default 32: the number of write bytes accepted per frame before NACK.
REQ-003 SHALL have port clk  input  1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1: synchronous active-low reset, sampled on clk.
REQ-005 SHALL have port scl  input  1: I2C clock from the bus master; asynchronous to clk.
REQ-006 SHALL have port sda  inout  1: I2C data; the block drives 0 or high-Z only, never 1.
REQ-007 SHALL have port rx_data  output  8: the last received write byte.
REQ-008 SHALL have port rx_valid  output  1: a one-clk pulse marking rx_data as new.
REQ-009 SHALL have port tx_data  input  8: the byte to return on a read transfer.
REQ-010 SHALL have port tx_req  output  1: a one-clk pulse when tx_data has been latched; the next byte must be presented.
REQ-011 SHALL have port byte_count  output  6: the number of data bytes ACKed in the current frame.
REQ-012 SHALL have port busy  output  1: high from an address match until STOP.
REQ-013 SHALL have port overflow  output  1: sticky per frame; set when a write byte beyond MAX_BYTES arrives.
REQ-014 SHALL have port frame_done  output  1: a one-clk pulse on STOP following an address match.

Function
REQ-015 SHALL synchronise scl and sda through 2 flops each, plus one history flop for edge detection; all bus events SHALL use the synchronised values.
REQ-016 SHALL detect START as a synced sda falling edge while synced scl is high, and STOP as a synced sda rising edge while synced scl is high.
REQ-017 SHALL implement the states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK and WAIT_STOP.
REQ-018 SHALL handle START from any state by going to ADDR, clearing the bit counter, byte_count and overflow; a repeated START is included.
REQ-019 SHALL handle STOP from any state by going to IDLE, releasing sda and dropping busy; it SHALL pulse frame_done if busy was high.
REQ-020 SHALL sample data bits MSB-first on the synced scl rising edge and SHALL change sda only on the synced scl falling edge.
REQ-021 SHALL, in ADDR after 8 bits, go to ADDR_ACK when addr[7:1]==SLV_ADDR; otherwise it SHALL go to IDLE with sda never driven.
REQ-022 SHALL, in ADDR_ACK, drive sda low from the falling edge after bit 8 until the next falling edge; it SHALL then go to RX if R/W=0 or to TX if R/W=1.
REQ-023 SHALL, in RX after 8 bits, update rx_data and pulse rx_valid one clk after the 8th-bit sample when byte_count<MAX_BYTES, increment byte_count and ACK via RX_ACK.
REQ-024 SHALL, in RX when byte_count==MAX_BYTES, leave rx_data and rx_valid untouched, set overflow, NACK (release sda) and go to WAIT_STOP.
REQ-025 SHALL, on entering TX, latch tx_data into the shift register at the scl falling edge and pulse tx_req on the same clk cycle.
REQ-026 SHALL, in TX, drive sda low for each 0 bit and release it for each 1 bit, then release sda in TX_ACK.
REQ-027 SHALL, in TX_ACK, increment byte_count and return to TX when the master ACKs (sda=0 at scl rise); a master NACK SHALL go to WAIT_STOP.
REQ-028 SHALL saturate byte_count at MAX_BYTES and never wrap it.
REQ-029 SHALL give STOP priority over START if both are detected in one clk, and SHALL give START/STOP priority over a bit sample.

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, put the state in IDLE, release sda and set rx_data=0, rx_valid=0, tx_req=0, byte_count=0, busy=0, overflow=0 and frame_done=0.
REQ-031 SHALL, when reset is asserted mid-byte, release sda in the first clk with rst_n=0; after reset the block SHALL ignore the bus until the next START.

Structure
REQ-032 SHALL take the state encoding, the ACK=0/NACK=1 constants and the address width 7 from shared package i2c_pkg.
REQ-033 SHALL place synchronisation and START/STOP/edge detection in sub-module i2c_line_sync, which outputs scl_rise, scl_fall, start_det and stop_det.

Verification
REQ-034 SHALL test a write: START, 0x78, 0xA5, 0x5A, STOP -> 3 ACKs, rx_valid pulses with 0xA5 then 0x5A, byte_count=2, one frame_done pulse.
REQ-035 SHALL test an address miss: START, 0x7A, 0x11, STOP -> sda never driven, no rx_valid, busy=0, no frame_done.
REQ-036 SHALL test a read: START, 0x79, with tx_data 0x81 then 0x3C, master ACK then NACK -> bus bits 10000001 and 00111100, 2 tx_req pulses, state WAIT_STOP.
REQ-037 SHALL test overflow: write 33 bytes 0x00..0x20 -> 32 ACKs, 33rd byte NACKed, overflow=1, byte_count=32, rx_data=0x1F.
REQ-038 SHALL test a repeated START: write 0x78, 0x01, then START, 0x79 read -> byte_count cleared to 0, TX entered, tx_req pulses.
REQ-039 SHALL test reset during ACK low: apply rst_n=0 -> sda high-Z next clk, all outputs at reset values, no ACK on the following byte without a new START.
